// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation enum, funct codes,
// FSM state type, pass-through control bundle and the ALU decode helper.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MULT,
    ALU_NONE
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } ex_state_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  // Control bits carried unchanged from ID/EX to EX/MEM.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
  } ex_ctrl_t;

  // Map alu_op/funct onto one ALU operation; unknown encodings give ALU_NONE.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_NONE;
    case (alu_op)
      2'b00: op = ALU_ADD;
      2'b01: op = ALU_SUB;
      2'b10: begin
        case (funct)
          FUNCT_ADD:  op = ALU_ADD;
          FUNCT_SUB:  op = ALU_SUB;
          FUNCT_AND:  op = ALU_AND;
          FUNCT_OR:   op = ALU_OR;
          FUNCT_SLT:  op = ALU_SLT;
          FUNCT_MULT: op = ALU_MULT;
          default:    op = ALU_NONE;
        endcase
      end
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_mult_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n, start (load a/b and begin), abort (drop any run),
//        a/b operands, busy (iterating), done (product valid, held until next
//        start or abort), product (low DATA_W bits of a*b).
module ex_mult_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  logic              run;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;

  // Only the low DATA_W product bits are kept, so the multiplicand simply
  // shifts out of range instead of needing a 2*DATA_W accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (abort) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (run && (cnt != LAST)) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign busy    = run && (cnt != LAST);
  assign done    = run && (cnt == LAST);
  assign product = acc;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute pipeline stage between ID/EX and EX/MEM valid/ready handshakes.
// Single-cycle ALU ops register their result one cycle after acceptance;
// mult (only when EX_STAGE_MULT_EN is defined) runs on ex_mult_seq and
// stalls the input for DATA_W+1 cycles. Without the macro, mult decodes as an
// unknown op (result 0, latency 1).
// Ports: clk, rst_n; in_valid/in_ready with operands rs_data, rt_data, imm,
//        register indices rt/rd, decode controls alu_src, reg_dst, alu_op,
//        funct and pass-through controls; flush; out_valid/out_ready with
//        out_alu, out_wd, out_rtrd and out_* controls (zero when not valid).
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wd,
  output logic [REG_AW-1:0] out_rtrd,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_mem_write,
  output logic              out_mem_read
);

  alu_op_e           op;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_res;
  logic [REG_AW-1:0] dst;
  ex_ctrl_t          ctrl_in;
  ex_ctrl_t          out_ctrl;

  logic              room;
  logic              drain;
  logic              idle;
  logic              accept;
  logic              is_mult;
  logic              load_alu;
  logic              mul_load;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] pend_wd;
  logic [REG_AW-1:0] pend_rtrd;
  ex_ctrl_t          pend_ctrl;

  // Operand mux, destination mux and single-cycle ALU.
  always_comb begin
    op      = alu_decode(alu_op, funct);
    opb     = alu_src ? imm : rt_data;
    dst     = reg_dst ? rd : rt;
    ctrl_in = {reg_write, mem_to_reg, mem_write, mem_read};
    alu_res = '0;
    case (op)
      ALU_ADD: alu_res = rs_data + opb;
      ALU_SUB: alu_res = rs_data - opb;
      ALU_AND: alu_res = rs_data & opb;
      ALU_OR:  alu_res = rs_data | opb;
      ALU_SLT: alu_res = DATA_W'($signed(rs_data) < $signed(opb));
      default: alu_res = '0;
    endcase
  end

  assign room     = !out_valid || out_ready;
  assign drain    = out_valid && out_ready;
  assign in_ready = idle && room;
  assign accept   = in_valid && in_ready && !flush;
  assign load_alu = accept && !is_mult;

`ifdef EX_STAGE_MULT_EN
  ex_state_e state;
  ex_state_e state_nx;
  logic      mul_busy;
  logic      mul_done;

  assign is_mult = (op == ALU_MULT);
  assign idle    = (state == ST_IDLE);
  // Product only moves into the output register once that register is free.
  assign mul_load = (state == ST_MUL) && mul_done && !mul_busy && room && !flush;

  ex_mult_seq #(.DATA_W(DATA_W)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mult),
    .abort   (flush),
    .a       (rs_data),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept && is_mult) state_nx = ST_MUL;
        ST_MUL:  if (mul_load)          state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Side-band fields of the mult, held while it iterates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wd   <= '0;
      pend_rtrd <= '0;
      pend_ctrl <= '0;
    end else if (accept && is_mult) begin
      pend_wd   <= rt_data;
      pend_rtrd <= dst;
      pend_ctrl <= ctrl_in;
    end
  end
`else
  assign is_mult     = 1'b0;
  assign idle        = 1'b1;
  assign mul_load    = 1'b0;
  assign mul_product = '0;
  assign pend_wd     = '0;
  assign pend_rtrd   = '0;
  assign pend_ctrl   = '0;
`endif

  // EX/MEM output register; payload is forced to zero whenever invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_alu   <= '0;
      out_wd    <= '0;
      out_rtrd  <= '0;
      out_ctrl  <= '0;
    end else if (flush || (drain && !load_alu && !mul_load)) begin
      out_valid <= 1'b0;
      out_alu   <= '0;
      out_wd    <= '0;
      out_rtrd  <= '0;
      out_ctrl  <= '0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      out_alu   <= alu_res;
      out_wd    <= rt_data;
      out_rtrd  <= dst;
      out_ctrl  <= ctrl_in;
    end else if (mul_load) begin
      out_valid <= 1'b1;
      out_alu   <= mul_product;
      out_wd    <= pend_wd;
      out_rtrd  <= pend_rtrd;
      out_ctrl  <= pend_ctrl;
    end
  end

  assign {out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read} = out_ctrl;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: a driver issues directed and random
// instructions and pushes model results; a monitor pops on each new output,
// checks hold stability, zero payload when idle, and result latency.
module tb_ex_stage_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] rs_data, rt_data, imm;
  logic [AW-1:0] rt, rd;
  logic          alu_src, reg_dst;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic          reg_write, mem_to_reg, mem_write, mem_read;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_alu, out_wd;
  logic [AW-1:0] out_rtrd;
  logic          out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read;
  logic [3:0]    octrl;

  assign octrl = {out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read};

  typedef struct {
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [DW-1:0] rs, rtv, imm;
    logic [AW-1:0] rt_i, rd_i;
    logic          alu_src, reg_dst;
    logic [3:0]    ctrl;
  } txn_t;

  typedef struct {
    logic [DW-1:0] alu, wd;
    logic [AW-1:0] rtrd;
    logic [3:0]    ctrl;
    int unsigned   due;
    bit            exact;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          ready_mode = 1;  // 0 random, 1 always ready, 2 never ready
  bit          stop = 0;

  ex_stage_pipe #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .rt(rt), .rd(rd),
    .alu_src(alu_src), .reg_dst(reg_dst), .alu_op(alu_op), .funct(funct),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .mem_read(mem_read), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu(out_alu), .out_wd(out_wd),
    .out_rtrd(out_rtrd), .out_reg_write(out_reg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
    .out_mem_read(out_mem_read)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: instruction semantics in plain arithmetic.
  function automatic exp_t model(input txn_t t, input int unsigned acc);
    exp_t          e;
    logic [DW-1:0] b;
    bit            mul;
    b   = t.alu_src ? t.imm : t.rtv;
    mul = 0;
    e.alu = '0;
    if (t.alu_op == 2'd0) e.alu = t.rs + b;
    else if (t.alu_op == 2'd1) e.alu = t.rs - b;
    else if (t.alu_op == 2'd2) begin
      case (t.funct)
        6'h20: e.alu = t.rs + b;
        6'h22: e.alu = t.rs - b;
        6'h24: e.alu = t.rs & b;
        6'h25: e.alu = t.rs | b;
        6'h2A: e.alu = ($signed(t.rs) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_STAGE_MULT_EN
        6'h18: begin e.alu = t.rs * b; mul = 1; end
`endif
        default: e.alu = '0;
      endcase
    end
    e.wd    = t.rtv;
    e.rtrd  = t.reg_dst ? t.rd_i : t.rt_i;
    e.ctrl  = t.ctrl;
    e.due   = mul ? acc + DW + 1 : acc;
    e.exact = !mul || (ready_mode == 1);
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.alu_op = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 6))
      0: t.funct = 6'h20;
      1: t.funct = 6'h22;
      2: t.funct = 6'h24;
      3: t.funct = 6'h25;
      4: t.funct = 6'h2A;
      5: t.funct = 6'h18;
      default: t.funct = 6'($urandom);
    endcase
    t.rs      = rnd_val();
    t.rtv     = rnd_val();
    t.imm     = rnd_val();
    t.rt_i    = 5'($urandom);
    t.rd_i    = 5'($urandom);
    t.alu_src = 1'($urandom);
    t.reg_dst = 1'($urandom);
    t.ctrl    = 4'($urandom);
    return t;
  endfunction

  function automatic txn_t mk(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im, input logic src,
                              input logic [3:0] ctl);
    txn_t t;
    t.alu_op = op; t.funct = fn; t.rs = a; t.rtv = b; t.imm = im;
    t.rt_i = 5'd3; t.rd_i = 5'd9; t.alu_src = src; t.reg_dst = 1'b0; t.ctrl = ctl;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    alu_op = t.alu_op; funct = t.funct; rs_data = t.rs; rt_data = t.rtv; imm = t.imm;
    rt = t.rt_i; rd = t.rd_i; alu_src = t.alu_src; reg_dst = t.reg_dst;
    {reg_write, mem_to_reg, mem_write, mem_read} = t.ctrl;
  endtask

  // Present one instruction (or a flush) until it is taken, bounded.
  task automatic issue(input txn_t t, input bit fl);
    int tries = 0;
    bit taken = 0;
    while (!taken) begin
      @(negedge clk);
      drive(t);
      in_valid = 1'b1;
      flush    = fl;
      #3;
      if (fl) begin
        sb.delete();
        taken = 1;
      end else if (in_ready) begin
        sb.push_back(model(t, cyc + 1));
        taken = 1;
      end else if (++tries > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout in_ready stuck low after %0d cycles", tries);
        taken = 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (fl) begin
      @(negedge clk);
      #3;
      chk("flush_out_valid", 96'(out_valid), 96'd0);
      chk("flush_in_ready", 96'(in_ready), 96'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(rnd_txn());
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Monitor: pop and compare on each newly presented output.
  initial begin
    bit            held = 0;
    logic [95:0]   hv = '0;
    exp_t          e;
    wait (rst_n === 1'b1);
    while (!stop) begin
      @(negedge clk);
      #2;
      if (flush)                out_ready = 1'b0;
      else if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
      else                      out_ready = (ready_mode == 1);
      if (!out_valid) begin
        held = 0;
        chk("idle_zero", 96'({out_alu, out_wd, out_rtrd, octrl}), 96'd0);
      end else if (held) begin
        chk("hold_stable", 96'({out_alu, out_wd, out_rtrd, octrl}), hv);
      end else if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output alu=%0h with empty scoreboard", out_alu);
      end else begin
        e = sb.pop_front();
        chk("out_alu", 96'(out_alu), 96'(e.alu));
        chk("out_wd", 96'(out_wd), 96'(e.wd));
        chk("out_rtrd", 96'(out_rtrd), 96'(e.rtrd));
        chk("out_ctrl", 96'(octrl), 96'(e.ctrl));
        if (e.exact) chk("latency", 96'(cyc), 96'(e.due));
        else begin
          checks++;
          if (cyc < e.due) begin
            errors++;
            $display("FAIL latency_early actual=%0d required>=%0d", cyc, e.due);
          end
        end
      end
      if (out_valid) begin
        held = !out_ready;
        hv   = 96'({out_alu, out_wd, out_rtrd, octrl});
      end
    end
  end

  // Driver: reset, directed cases, random traffic, drain, summary.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(rnd_txn());
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 96'(out_valid), 96'd0);
    chk("reset_payload", 96'({out_alu, out_wd, out_rtrd, octrl}), 96'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    chk("reset_in_ready", 96'(in_ready), 96'd1);

    ready_mode = 1;
    issue(mk(2'b10, 6'h20, 32'd7, 32'd5, 32'd0, 1'b0, 4'b1000), 0);
    issue(mk(2'b00, 6'h00, 32'h100, 32'd0, 32'hFFFF_FFFC, 1'b1, 4'b1101), 0);
    issue(mk(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b1000), 0);
    issue(mk(2'b01, 6'h00, 32'd0, 32'd1, 32'd0, 1'b0, 4'b1000), 0);
    issue(mk(2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 4'b0010), 0);
    issue(mk(2'b11, 6'h20, 32'd3, 32'd4, 32'd0, 1'b0, 4'b0001), 0);
    idle(2);
    issue(mk(2'b10, 6'h18, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0, 4'b1000), 0);
    idle(40);

    // Output stalled for 5 cycles with three adds queued behind it.
    ready_mode = 2;
    issue(mk(2'b00, 6'h00, 32'd1, 32'd1, 32'd0, 1'b0, 4'b1000), 0);
    fork
      begin repeat (5) @(negedge clk); ready_mode = 1; end
    join_none
    issue(mk(2'b00, 6'h00, 32'd2, 32'd2, 32'd0, 1'b0, 4'b1000), 0);
    issue(mk(2'b00, 6'h00, 32'd3, 32'd3, 32'd0, 1'b0, 4'b1000), 0);
    idle(3);

    // Flush ten cycles into a mult, with in_valid high on the flush cycle.
    issue(mk(2'b10, 6'h18, 32'd12345, 32'd678, 32'd0, 1'b0, 4'b1000), 0);
    idle(9);
    issue(rnd_txn(), 1);
    // Flush killing a result parked in the output register.
    ready_mode = 2;
    issue(mk(2'b00, 6'h00, 32'd9, 32'd9, 32'd0, 1'b0, 4'b1000), 0);
    issue(rnd_txn(), 1);
    idle(2);

    ready_mode = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
      issue(rnd_txn(), ($urandom_range(0, 32) == 0));
    end

    ready_mode = 1;
    idle(1);
    for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d out_valid=%0b", sb.size(), out_valid);
    end
    stop = 1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
